// File: rtl/lcd_hex_font.vh
// 8x8 hex glyphs '0'-'9','A'-'F' for the hex-dump renderer.
// Row 0 is the top byte of each 64-bit word; bit 7 of a row is the leftmost pixel.
function automatic logic [7:0] hex_font_row(input logic [3:0] digit, input logic [2:0] row);
   logic [63:0] glyph;
   case (digit)
      4'h0: glyph = 64'h3C666E7666663C00;
      4'h1: glyph = 64'h1838181818187E00;
      4'h2: glyph = 64'h3C66060C30607E00;
      4'h3: glyph = 64'h3C66061C06663C00;
      4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
      4'h5: glyph = 64'h7E607C0606663C00;
      4'h6: glyph = 64'h3C66607C66663C00;
      4'h7: glyph = 64'h7E660C1818181800;
      4'h8: glyph = 64'h3C66663C66663C00;
      4'h9: glyph = 64'h3C66663E06663C00;
      4'hA: glyph = 64'h183C667E66666600;
      4'hB: glyph = 64'h7C66667C66667C00;
      4'hC: glyph = 64'h3C66606060663C00;
      4'hD: glyph = 64'h786C6666666C7800;
      4'hE: glyph = 64'h7E60607860607E00;
      default: glyph = 64'h7E60607860606000;
   endcase
   return glyph[{~row, 3'b000} +: 8];
endfunction

// File: rtl/lcd_hex_display.sv
// Hex-dump pixel source: UART bytes in a circular buffer, rendered as two hex digits + blank per byte.
// Optional blinking write cursor enabled by defining LCD_HEX_CURSOR_EN.
module lcd_hex_display #(
   parameter int          BYTES_PER_ROW = 8,
   parameter int          ROWS          = 16,
   parameter int          SCALE         = 2,
   parameter logic [23:0] FG_COLOR      = 24'hFFFFFF,
   parameter logic [23:0] BG_COLOR      = 24'h000000
) (
   input  logic        lcd_pclk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        clear,
   input  logic [10:0] pixel_x,
   input  logic [10:0] pixel_y,
   input  logic [10:0] h_disp,
   input  logic [10:0] v_disp,
   output logic [23:0] pixel_data,
   output logic [15:0] byte_cnt
);

   `include "lcd_hex_font.vh"

   localparam int                DEPTH       = BYTES_PER_ROW * ROWS;
   localparam int                IDX_W       = $clog2(DEPTH);
   localparam int                CELL_SHIFT  = $clog2(8 * SCALE);
   localparam int                SCALE_SHIFT = $clog2(SCALE);
   localparam logic [10:0]       X_LIMIT     = 11'(3 * BYTES_PER_ROW * 8 * SCALE);
   localparam logic [10:0]       ROW_LIMIT   = 11'(ROWS);
   localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(DEPTH - 1);

   logic [7:0]       mem [DEPTH];
   logic [DEPTH-1:0] valid_reg;
   logic [DEPTH-1:0] wr_hit;
   logic [IDX_W-1:0] wr_ptr_reg;
   logic [IDX_W-1:0] wr_ptr_next;
   logic [15:0]      byte_cnt_reg;
   logic [23:0]      pixel_reg;
   logic [23:0]      pixel_next;
   logic             do_write;

   // clear has priority: a byte arriving in the same cycle is dropped
   assign do_write    = rx_valid & ~clear;
   assign wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + IDX_W'(1);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_hit
      assign wr_hit[gi] = do_write && (wr_ptr_reg == IDX_W'(gi));
   end

   always_ff @(posedge lcd_pclk) begin
      if (do_write) begin
         mem[wr_ptr_reg] <= rx_data;
      end
   end

   // ---------------- address decode ----------------
   logic [10:0]      y0;
   logic [10:0]      cell_col;
   logic [10:0]      cell_row;
   logic [10:0]      byte_col;
   logic [1:0]       phase;
   logic [15:0]      idx_full;
   logic [IDX_W-1:0] idx;
   logic [2:0]       glyph_row;
   logic [2:0]       glyph_col;
   logic [7:0]       cell_byte;
   logic [3:0]       digit;
   logic [7:0]       row_bits;
   logic             glyph_bit;
   logic             in_area;
   logic             cell_valid;
   logic             lit;
   logic             cursor_hit;
   logic             unused_idx_hi;

   assign y0        = pixel_y - 11'd1;
   assign cell_col  = pixel_x >> CELL_SHIFT;
   assign cell_row  = y0 >> CELL_SHIFT;
   assign byte_col  = cell_col / 11'd3;
   assign phase     = 2'(cell_col % 11'd3);
   assign idx_full  = 16'(cell_row) * 16'(BYTES_PER_ROW) + 16'(byte_col);
   assign idx       = idx_full[IDX_W-1:0];
   assign glyph_row = y0[SCALE_SHIFT +: 3];
   assign glyph_col = pixel_x[SCALE_SHIFT +: 3];

   // idx is only meaningful inside the text area, where it never exceeds DEPTH-1
   assign unused_idx_hi = ^idx_full[15:IDX_W];

   // Distributed read: a write at edge E is seen by the output register from edge E+1 on
   assign cell_byte  = mem[idx];
   assign digit      = (phase == 2'd0) ? cell_byte[7:4] : cell_byte[3:0];
   assign row_bits   = hex_font_row(digit, glyph_row);
   assign glyph_bit  = row_bits[~glyph_col];
   assign cell_valid = valid_reg[idx];

   assign in_area = (pixel_y != 11'd0) && (pixel_x < X_LIMIT) && (cell_row < ROW_LIMIT);
   assign lit     = in_area && (phase != 2'd2) && cell_valid && glyph_bit;

`ifdef LCD_HEX_CURSOR_EN
   logic [5:0] frame_cnt_reg;
   logic       frame_tick;

   assign frame_tick = (pixel_y == v_disp) && (pixel_x == h_disp - 11'd1);

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_reg <= '0;
      end else if (frame_tick) begin
         frame_cnt_reg <= frame_cnt_reg + 6'd1;
      end
   end

   // Blink period: 32 frames shown, 32 frames inverted, on the high-nibble cell of wr_ptr
   assign cursor_hit = frame_cnt_reg[5] && in_area && (phase == 2'd0) && (idx == wr_ptr_reg);
`else
   logic unused_disp;
   assign unused_disp = ^{h_disp, v_disp};
   assign cursor_hit  = 1'b0;
`endif

   always_comb begin
      pixel_next = BG_COLOR;
      if (cursor_hit) begin
         if (!(cell_valid && glyph_bit)) begin
            pixel_next = FG_COLOR;
         end
      end else if (lit) begin
         pixel_next = FG_COLOR;
      end
   end

   always_ff @(posedge lcd_pclk or negedge rst_n) begin
      if (!rst_n) begin
         valid_reg    <= '0;
         wr_ptr_reg   <= '0;
         byte_cnt_reg <= '0;
         pixel_reg    <= '0;
      end else begin
         pixel_reg <= pixel_next;
         if (clear) begin
            valid_reg    <= '0;
            wr_ptr_reg   <= '0;
            byte_cnt_reg <= '0;
         end else if (rx_valid) begin
            valid_reg  <= valid_reg | wr_hit;
            wr_ptr_reg <= wr_ptr_next;
            if (byte_cnt_reg != 16'hFFFF) begin
               byte_cnt_reg <= byte_cnt_reg + 16'd1;
            end
         end
      end
   end

   assign pixel_data = pixel_reg;
   assign byte_cnt   = byte_cnt_reg;

endmodule

// File: tb/tb_lcd_hex_display.sv
// Randomized bench for lcd_hex_display against a coordinate-level reference model.
// Build with LCD_HEX_CURSOR_EN defined to also model the blinking cursor.
`timescale 1ns/1ps
module tb_lcd_hex_display;

   localparam int          BPR   = 8;
   localparam int          ROWS  = 16;
   localparam int          SCALE = 2;
   localparam int          DEPTH = BPR * ROWS;
   localparam int          CELL  = 8 * SCALE;
   localparam int          H     = 480;
   localparam int          V     = 272;
   localparam logic [23:0] FG    = 24'hFFFFFF;
   localparam logic [23:0] BG    = 24'h000000;

   localparam logic [63:0] FONT [16] = '{
      64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
      64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C66607C66663C00, 64'h7E660C1818181800,
      64'h3C66663C66663C00, 64'h3C66663E06663C00, 64'h183C667E66666600, 64'h7C66667C66667C00,
      64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607860607E00, 64'h7E60607860606000
   };

   logic        lcd_pclk = 1'b0;
   logic        rst_n    = 1'b0;
   logic [7:0]  rx_data  = 8'h00;
   logic        rx_valid = 1'b0;
   logic        clear    = 1'b0;
   logic [10:0] pixel_x  = 11'd0;
   logic [10:0] pixel_y  = 11'd0;
   logic [10:0] h_disp   = 11'(H);
   logic [10:0] v_disp   = 11'(V);
   logic [23:0] pixel_data;
   logic [15:0] byte_cnt;

   lcd_hex_display dut (
      .lcd_pclk  (lcd_pclk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .clear     (clear),
      .pixel_x   (pixel_x),
      .pixel_y   (pixel_y),
      .h_disp    (h_disp),
      .v_disp    (v_disp),
      .pixel_data(pixel_data),
      .byte_cnt  (byte_cnt)
   );

   always #5 lcd_pclk = ~lcd_pclk;

   int assert_cnt = 0;
   int fail_cnt   = 0;

   // reference state
   logic [7:0] m_data  [DEPTH];
   bit         m_valid [DEPTH];
   int         m_wr       = 0;
   int         m_cnt      = 0;
   int         m_frames   = 0;
   bit         m_in_reset = 1'b1;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assert_cnt++;
      if (obs !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model_pixel(input int x, input int y);
      int         y0, cr, cc, bc, ph, idx, gr, gc;
      logic [63:0] glyph;
      logic [7:0]  rb;
      logic [3:0]  nib;
      bit          on;
      if (m_in_reset) return 24'h0;
      if (y == 0 || x >= 3 * BPR * CELL) return BG;
      y0 = y - 1;
      cr = y0 / CELL;
      if (cr >= ROWS) return BG;
      cc  = x / CELL;
      bc  = cc / 3;
      ph  = cc % 3;
      idx = cr * BPR + bc;
      on  = 1'b0;
      if (ph != 2 && m_valid[idx]) begin
         nib   = (ph == 0) ? m_data[idx][7:4] : m_data[idx][3:0];
         glyph = FONT[nib];
         gr    = (y0 / SCALE) % 8;
         gc    = (x / SCALE) % 8;
         rb    = glyph[8 * (7 - gr) +: 8];
         on    = rb[7 - gc];
      end
`ifdef LCD_HEX_CURSOR_EN
      if (((m_frames / 32) % 2) == 1 && ph == 0 && idx == m_wr) on = !on;
`endif
      return on ? FG : BG;
   endfunction

   function automatic void model_reset_buffer();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
      m_wr  = 0;
      m_cnt = 0;
   endfunction

   // Called at posedge+1: presents a coordinate, checks the pixel one edge later.
   task automatic present(input int x, input int y, input string tag);
      logic [23:0] exp;
      pixel_x = 11'(x);
      pixel_y = 11'(y);
      exp = model_pixel(x, y);
      if (!m_in_reset && x == H - 1 && y == V) m_frames++;
      @(posedge lcd_pclk);
      #1;
      check_eq($sformatf("%s(%0d,%0d)", tag, x, y), 32'(pixel_data), 32'(exp));
   endtask

   task automatic sweep_box(input int x0, input int x1, input int y0, input int y1, input string tag);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            present(x, y, tag);
      $display("sweep %s x %0d..%0d y %0d..%0d done, failures so far %0d", tag, x0, x1, y0, y1, fail_cnt);
   endtask

   task automatic sweep_random(input int n, input string tag);
      for (int i = 0; i < n; i++)
         present(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V)), tag);
      $display("random sweep %s of %0d pixels done, failures so far %0d", tag, n, fail_cnt);
   endtask

   task automatic write_byte(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      pixel_x  = 11'd0;
      pixel_y  = 11'd0;
      @(posedge lcd_pclk);
      #1;
      rx_valid     = 1'b0;
      m_data[m_wr]  = d;
      m_valid[m_wr] = 1'b1;
      m_wr         = (m_wr + 1) % DEPTH;
      if (m_cnt < 65535) m_cnt++;
      check_eq("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
      $display("write %02h -> byte_cnt %0d", d, m_cnt);
   endtask

   task automatic do_clear(input bit with_byte);
      clear    = 1'b1;
      rx_valid = with_byte;
      rx_data  = 8'hFF;
      pixel_x  = 11'd0;
      pixel_y  = 11'd0;
      @(posedge lcd_pclk);
      #1;
      clear    = 1'b0;
      rx_valid = 1'b0;
      model_reset_buffer();
      check_eq("clear_cnt", 32'(byte_cnt), 32'd0);
      $display("clear (rx_valid=%0d) -> byte_cnt %0d", with_byte, byte_cnt);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] exp_old;
      int          cx, cy;
      model_reset_buffer();

      // 1. reset held, then an empty screen
      @(posedge lcd_pclk);
      #1;
      for (int i = 0; i < 50; i++)
         present(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V)), "in_reset");
      check_eq("rst_byte_cnt", 32'(byte_cnt), 32'd0);
      rst_n      = 1'b1;
      m_in_reset = 1'b0;
      m_frames   = 0;
      sweep_random(2000, "empty");
      check_eq("empty_byte_cnt", 32'(byte_cnt), 32'd0);

      // 2. single byte A5, same-edge read still sees the old (invalid) entry
      exp_old  = model_pixel(6, 1);
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      pixel_x  = 11'd6;
      pixel_y  = 11'd1;
      @(posedge lcd_pclk);
      #1;
      rx_valid   = 1'b0;
      m_data[0]  = 8'hA5;
      m_valid[0] = 1'b1;
      m_wr       = 1;
      m_cnt      = 1;
      check_eq("vis_same_edge", 32'(pixel_data), 32'(exp_old));
      present(6, 1, "vis_next_edge");
      check_eq("a5_byte_cnt", 32'(byte_cnt), 32'd1);
      $display("write a5 with same-cycle read -> byte_cnt %0d", byte_cnt);
      sweep_box(0, 47, 1, 16, "a5");

      // 3. nine bytes 00..08: wrap onto the second text row
      do_clear(1'b0);
      for (int i = 0; i < 9; i++) write_byte(8'(i));
      sweep_box(0, H - 1, 0, 34, "nine");

      // 4. 129 bytes: entry 0 overwritten by 80
      do_clear(1'b0);
      for (int i = 0; i < 129; i++) write_byte(8'(i % 256));
      check_eq("wrap_byte_cnt", 32'(byte_cnt), 32'd129);
      sweep_box(0, 95, 1, 16, "wrap_head");
      sweep_box(0, 399, 250, V, "wrap_tail");
      sweep_random(3000, "wrap_rand");

      // 5. clear beats a simultaneous byte
      do_clear(1'b1);
      sweep_random(2000, "after_clear");
      write_byte(8'h3C);
      sweep_box(0, 47, 1, 16, "post_clear");

      // 6. 64 frames around the cursor cell
      do_clear(1'b0);
      for (int i = 0; i < 3; i++) write_byte(8'($urandom_range(0, 255)));
      cx = (m_wr % BPR) * 3 * CELL;
      cy = (m_wr / BPR) * CELL + 1;
      for (int f = 0; f < 64; f++) begin
         for (int p = 0; p < 16; p++)
            present(cx + int'($urandom_range(0, CELL - 1)), cy + int'($urandom_range(0, CELL - 1)), "cursor");
         present(cx - CELL + int'($urandom_range(0, CELL - 1)), cy + int'($urandom_range(0, CELL - 1)), "cursor_nb");
         present(H - 1, V, "frame_tick");
      end
      $display("cursor frames done, model frame count %0d, failures so far %0d", m_frames, fail_cnt);

      // 7. asynchronous reset in the middle of a frame
      do_clear(1'b0);
      write_byte(8'hA5);
      write_byte(8'h5A);
      present(6, 1, "pre_reset");
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_pixel", 32'(pixel_data), 32'd0);
      check_eq("async_rst_cnt", 32'(byte_cnt), 32'd0);
      m_in_reset = 1'b1;
      model_reset_buffer();
      m_frames = 0;
      @(posedge lcd_pclk);
      #1;
      rst_n      = 1'b1;
      m_in_reset = 1'b0;
      $display("async reset mid-frame applied and released");
      sweep_box(0, 95, 1, 16, "post_reset");
      check_eq("post_reset_cnt", 32'(byte_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
